// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared state type, peripheral address map and timing default for the IO bus arbiter
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam int WAIT_CYCLES_DEFAULT = 2;

    // Memory-mapped peripherals sit at the very top of the address space.
    localparam logic [31:0] ADDR_LED    = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDR_SWITCH = 32'hFFFF_FFFE;
    localparam logic [31:0] ADDR_BUTTON = 32'hFFFF_FFFD;
    localparam logic [31:0] ADDR_SEG7   = 32'hFFFF_FFFC;
    localparam logic [31:0] ADDR_UART   = 32'hFFFF_FFFB;
    localparam logic [31:0] ADDR_LCD    = 32'hFFFF_FFFA;
    localparam logic [31:0] ADDR_ROTARY = 32'hFFFF_FFF9;

endpackage

// File: rtl/io_rr_picker.sv
// rtl/io_rr_picker.sv - two-master winner selection; fairness on ties when IO_ARB_ROUND_ROBIN_EN is defined
module io_rr_picker (
    input  logic [1:0] reqs,
    input  logic       last_grant,
    output logic       grant
);

`ifdef IO_ARB_ROUND_ROBIN_EN
    // On a tie the master that did not win last time goes next.
    assign grant = (&reqs) ? ~last_grant : (reqs[1] & ~reqs[0]);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant             = reqs[1] & ~reqs[0];
`endif

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master IO bus arbiter with fixed wait states; tie policy set by IO_ARB_ROUND_ROBIN_EN
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_wdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [AW-1:0] rdata,
    output logic [AW-1:0] bus_addr,
    output logic          bus_memwrite,
    output logic [AW-1:0] bus_wdata,
    input  logic [AW-1:0] bus_rdata,
    output logic          busy
);

    arb_state_t    state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] lat_addr;
    logic [AW-1:0] lat_wdata;
    logic          lat_we;
    logic          lat_grant;
    logic          last_grant;
    logic          pick;

    io_rr_picker u_picker (
        .reqs       ({m1_req, m0_req}),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // The bus only carries the latched transfer while an access is in flight.
    assign bus_addr     = (state == ACCESS) ? lat_addr  : '0;
    assign bus_wdata    = (state == ACCESS) ? lat_wdata : '0;
    assign bus_memwrite = (state == ACCESS) && (wait_cnt == 4'd0) && lat_we;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            rdata      <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_grant  <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        lat_grant  <= pick;
                        last_grant <= pick;
                        lat_addr   <= pick ? m1_addr  : m0_addr;
                        lat_wdata  <= pick ? m1_wdata : m0_wdata;
                        lat_we     <= pick ? m1_we    : m0_we;
                        wait_cnt   <= 4'(WAIT_CYCLES);
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        if (!lat_we) begin
                            rdata <= bus_rdata;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    m0_ack <= ~lat_grant;
                    m1_ack <= lat_grant;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - scoreboard bench for io_bus_arbiter (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 side instance)
module tb_io_bus_arbiter;
    import io_bus_pkg::*;

    localparam int W = 2;

    typedef struct {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack, bus_memwrite, busy;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;

    logic        z_req, z_m1_req;
    logic        z_m0_ack, z_m1_ack, z_bus_memwrite, z_busy;
    logic [31:0] z_rdata, z_bus_addr, z_bus_wdata, z_bus_rdata;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          ack_total = 0;
    int          strobe_total = 0;
    int          strobe_cnt = 0;
    logic [31:0] last_rd = '0;

    function automatic logic [31:0] periph(input logic [31:0] a);
        if (a == ADDR_SWITCH) return 32'h0000_003C;
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    assign bus_rdata   = periph(bus_addr);
    assign z_bus_rdata = periph(z_bus_addr);

    io_bus_arbiter #(.WAIT_CYCLES(W), .AW(32)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .rdata(rdata), .bus_addr(bus_addr), .bus_memwrite(bus_memwrite),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
    );

    io_bus_arbiter #(.WAIT_CYCLES(0), .AW(32)) u_dut0 (
        .clk(clk), .reset(reset),
        .m0_req(z_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_ack(z_m0_ack),
        .m1_req(z_m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_ack(z_m1_ack),
        .rdata(z_rdata), .bus_addr(z_bus_addr), .bus_memwrite(z_bus_memwrite),
        .bus_wdata(z_bus_wdata), .bus_rdata(z_bus_rdata), .busy(z_busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (!busy) begin
                check("idle_bus_addr", 64'(bus_addr), 64'd0);
                check("idle_memwrite", 64'(bus_memwrite), 64'd0);
            end
            if (bus_memwrite) begin
                strobe_total++;
                strobe_cnt++;
                check("strobe_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    check("strobe_addr", 64'(bus_addr), 64'(sb[0].addr));
                    check("strobe_wdata", 64'(bus_wdata), 64'(sb[0].wdata));
                end
            end
            if (m0_ack || m1_ack) begin
                exp_t e;
                ack_total++;
                check("ack_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("ack_master", 64'({m0_ack, m1_ack}), e.m ? 64'd1 : 64'd2);
                    if (!e.we) begin
                        check("rdata", 64'(rdata), 64'(e.rd));
                        last_rd = e.rd;
                    end else begin
                        check("rdata_held", 64'(rdata), 64'(last_rd));
                    end
                    check("strobe_count", 64'(strobe_cnt), e.we ? 64'd1 : 64'd0);
                end
                strobe_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; z_req = 1'b0;
        sb.delete();
        strobe_cnt = 0;
        last_rd = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic access(input logic m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int drop_at, input string tag);
        exp_t e;
        int   k;
        bit   seen;
        e.m = m; e.we = we; e.addr = addr; e.wdata = wdata; e.rd = periph(addr);
        sb.push_back(e);
        if (!m) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (drop_at != 0 && k == drop_at) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            if (m ? m1_ack : m0_ack) seen = 1;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'(W + 3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, bc, acks0, strobes0;
        logic [31:0] tbl [7];
        tbl = '{ADDR_LED, ADDR_SWITCH, ADDR_BUTTON, ADDR_SEG7, ADDR_UART, ADDR_LCD, ADDR_ROTARY};

        reset = 1'b1;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        z_req = 0; z_m1_req = 0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_acks", 64'({m0_ack, m1_ack}), 64'd0);
        check("rst_bus_addr", 64'(bus_addr), 64'd0);
        check("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        check("rst_memwrite", 64'(bus_memwrite), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        do_reset();

        access(1'b0, 1'b1, ADDR_LED, 32'h0000_00A5, 0, "m0_write_led");
        access(1'b1, 1'b0, ADDR_SWITCH, 32'h0, 0, "m1_read_switch");
        access(1'b1, 1'b0, ADDR_LCD, 32'h0, 2, "m1_drop_req");
        repeat (4) @(negedge clk);
        check("drop_single_ack", 64'(ack_total), 64'd3);

        for (int i = 0; i < 6; i++) begin
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   tbl[$urandom_range(0, 6)], $urandom, 0, "random");
        end
        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Simultaneous requests held from reset for two accesses.
        begin
            exp_t e;
            @(negedge clk);
            reset = 1'b1;
            sb.delete(); strobe_cnt = 0; last_rd = '0;
            m0_req = 1; m0_we = 0; m0_addr = ADDR_BUTTON;
            m1_req = 1; m1_we = 0; m1_addr = ADDR_SEG7;
            e.m = 1'b0; e.we = 1'b0; e.addr = ADDR_BUTTON; e.wdata = '0; e.rd = periph(ADDR_BUTTON);
            sb.push_back(e);
`ifdef IO_ARB_ROUND_ROBIN_EN
            e.m = 1'b1; e.addr = ADDR_SEG7; e.rd = periph(ADDR_SEG7);
`endif
            sb.push_back(e);
            @(negedge clk);
            reset = 1'b0;
            n = 0; k = 0;
            while (n < 2 && k < 40) begin
                @(negedge clk);
                k++;
                if (m0_ack || m1_ack) n++;
            end
            m0_req = 0; m1_req = 0;
            check("tie_two_acks", 64'(n), 64'd2);
            check("tie_second_latency", 64'(k), 64'(2 * (W + 3)));
        end

        // Reset pulse in the middle of a write access.
        @(negedge clk);
        acks0 = ack_total;
        strobes0 = strobe_total;
        m0_req = 1; m0_we = 1; m0_addr = ADDR_LCD; m0_wdata = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        m0_req = 0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_bus_addr", 64'(bus_addr), 64'd0);
        check("mid_rst_bus_wdata", 64'(bus_wdata), 64'd0);
        check("mid_rst_memwrite", 64'(bus_memwrite), 64'd0);
        check("mid_rst_rdata", 64'(rdata), 64'd0);
        check("mid_rst_acks", 64'({m0_ack, m1_ack}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete(); strobe_cnt = 0; last_rd = '0;
        repeat (8) @(negedge clk);
        check("mid_rst_no_ack", 64'(ack_total - acks0), 64'd0);
        check("mid_rst_no_strobe", 64'(strobe_total - strobes0), 64'd0);
        check("mid_rst_idle", 64'(busy), 64'd0);

        // Zero wait states on the side instance.
        do_reset();
        m0_we = 0; m0_addr = ADDR_SWITCH;
        z_req = 1;
        k = 0; bc = 0;
        begin
            bit seen;
            seen = 0;
            while (!seen && k < 20) begin
                @(negedge clk);
                k++;
                if (z_busy) bc++;
                if (z_m0_ack) seen = 1;
            end
        end
        z_req = 0;
        check("w0_latency", 64'(k), 64'd3);
        check("w0_rdata", 64'(z_rdata), 64'(periph(ADDR_SWITCH)));
        check("w0_m1_ack", 64'(z_m1_ack), 64'd0);
        repeat (3) begin
            @(negedge clk);
            if (z_busy) bc++;
        end
        check("w0_busy_cycles", 64'(bc), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of peripheral wait states per access (0..15).
REQ-002 SHALL have parameter AW, default 32, meaning the address and data width.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports m0_req/m1_req  input  1  access request from master 0 (CPU) and master 1 (serial loader).
REQ-006 SHALL have ports m0_addr/m1_addr  input  AW  the peripheral address, e.g. FFFF_FFFF LED, FFFF_FFFA LCD.
REQ-007 SHALL have ports m0_we/m1_we  input  1  write request, 0 = read.
REQ-008 SHALL have ports m0_wdata/m1_wdata  input  AW  write data.
REQ-009 SHALL have ports m0_ack/m1_ack  output  1  one-cycle completion pulse to the granted master.
REQ-010 SHALL have port rdata  output  AW  read data, valid while either ack is high.
REQ-011 SHALL have ports bus_addr  output  AW, bus_memwrite  output  1, bus_wdata  output  AW  driving the address decoder and peripherals.
REQ-012 SHALL have port bus_rdata  input  AW  the read data returned from the selected peripheral.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, ACCESS and DONE.
REQ-015 IDLE: when any req is sampled high, SHALL latch the winner's addr/we/wdata and the grant index, load wait_cnt=WAIT_CYCLES and go to ACCESS; otherwise SHALL remain in IDLE.
REQ-016 ACCESS: SHALL drive bus_addr/bus_wdata from the latched values throughout and decrement wait_cnt each cycle; at wait_cnt==0 SHALL go to DONE.
REQ-017 bus_memwrite SHALL be high only in the final ACCESS cycle (wait_cnt==0) and only for a write, so exactly one write strobe occurs per access.
REQ-018 On the final ACCESS edge, SHALL register bus_rdata into rdata (reads only; rdata is held for writes).
REQ-019 DONE: SHALL pulse the granted master's ack for exactly one cycle, then go to IDLE.
REQ-020 Latency: a req sampled in IDLE at edge N SHALL give ack high in the cycle following edge N+WAIT_CYCLES+2.
REQ-021 A master SHALL hold req and its inputs stable until ack; a req still high in the IDLE cycle after ack SHALL count as a new request.
REQ-022 A req dropped mid-access SHALL NOT abort the access; the access SHALL complete and ack SHALL still pulse.
REQ-023 A req arriving during ACCESS/DONE SHALL wait and is arbitrated in the next IDLE cycle.
REQ-024 When the bus is idle, bus_addr SHALL be 0 and bus_memwrite 0.

Reset
REQ-025 Reset SHALL force state=IDLE, wait_cnt=0, rdata=0, both acks=0, bus_memwrite=0, bus_addr=0, bus_wdata=0, busy=0 and last_grant=1.
REQ-026 Reset asserted mid-access SHALL abandon the access with no ack and no write strobe.

Configuration
REQ-027 Macro IO_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, SHALL grant the master not granted last (last_grant updates on each grant), so master 0 wins the first tie after reset.
REQ-028 Macro absent: on simultaneous requests, master 0 SHALL always win and last_grant SHALL be unused.

Structure
REQ-029 Package io_bus_pkg SHALL hold the state enum, the peripheral address constants (LED..ROTARY) and the WAIT_CYCLES default.
REQ-030 Winner selection SHALL be a sub-module io_rr_picker (inputs: reqs, last_grant; output: grant index).

Verification
REQ-031 Scenario: m0 write to FFFF_FFFF data 0000_00A5, WAIT=2 -> bus_memwrite high for exactly 1 cycle with bus_addr FFFF_FFFF, m0_ack in cycle N+4.
REQ-032 Scenario: m1 read of FFFF_FFFE with bus_rdata 0000_003C -> rdata=0000_003C with m1_ack high, bus_memwrite never high.
REQ-033 Scenario: both reqs high from reset, held for two accesses -> with the macro, grants are m0 then m1; without it, m0 then m0.
REQ-034 Scenario: reset pulse during ACCESS of a write -> no bus_memwrite, no ack, state IDLE, all outputs 0.
REQ-035 Scenario: WAIT_CYCLES=0, m0 read -> ack in cycle N+2, busy high for exactly 2 cycles.
REQ-036 Scenario: m1 drops req one cycle after the grant -> access completes and m1_ack still pulses once.
